mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner
// encoding and the latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Holds MEM_LAT, which ranges from 1 to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN. When defined, a tie goes to the
// requester that did not win the previous contested grant. When undefined,
// data always wins a tie and lastOwner is ignored.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifReq,
    input  logic       dReq,
    input  arb_owner_t lastOwner,
    output arb_owner_t winner,
    output logic       contested
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for the history bit.
    logic unusedLastOwner;
    assign unusedLastOwner = (lastOwner == OWN_D);
`endif

    // Pick the winner; a lone requester always wins, ties follow the policy.
    always_comb begin
        winner    = OWN_IF;
        contested = ifReq && dReq;
        if (contested) begin
`ifdef MEM_ARB_RR_EN
            winner = (lastOwner == OWN_IF) ? OWN_D : OWN_IF;
`else
            winner = OWN_D;
`endif
        end else if (dReq) begin
            winner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and
// load/store. Each granted transaction holds the port for MEM_LAT ACCESS
// cycles, captures read data on the last of them, then pulses the owner's
// done for one RESP cycle.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking, see
// mem_arb_pick).
//
// Handshake: a requester raises req and holds it until its done pulse; it
// drops req in the done cycle. Requests are sampled only in IDLE, so any
// change on req/addr/wdata during ACCESS or RESP has no effect.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              if_gnt,
    output logic              d_gnt,
    output logic              if_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output arb_state_t        dbgState
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    arb_state_t        state;
    arb_state_t        stateNext;
    arb_owner_t        owner;
    arb_owner_t        lastOwner;
    arb_owner_t        winner;
    logic              contested;
    logic              anyReq;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              memWrQ;

    assign anyReq = if_req || d_req;

    mem_arb_pick uPick (
        .ifReq     (if_req),
        .dReq      (d_req),
        .lastOwner (lastOwner),
        .winner    (winner),
        .contested (contested)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and outputs decoded from state and owner.
    always_comb begin
        stateNext = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if_gnt = (owner == OWN_IF);
                d_gnt  = (owner == OWN_D);
                if (cnt == ONE_CNT) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if_gnt    = (owner == OWN_IF);
                d_gnt     = (owner == OWN_D);
                if_done   = (owner == OWN_IF);
                d_done    = (owner == OWN_D);
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Latch the winning request in IDLE, count latency and capture read data.
    // memWrQ is set only on the grant edge, so the write strobe covers the
    // first ACCESS cycle alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_IF;
            lastOwner <= OWN_IF;
            cnt       <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdataQ    <= '0;
            memWrQ    <= 1'b0;
        end else begin
            memWrQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner <= winner;
                        cnt   <= LAT_CNT;
                        if (contested) begin
                            lastOwner <= winner;
                        end
                        if (winner == OWN_D) begin
                            addrQ  <= d_addr;
                            wdataQ <= d_wdata;
                            memWrQ <= d_wr;
                        end else begin
                            addrQ  <= if_addr;
                            memWrQ <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt - ONE_CNT;
                    if (cnt == ONE_CNT) begin
                        rdataQ <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign mem_wr    = memWrQ;
    assign rdata     = rdataQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with MEM_LAT=2.
// Build with MEM_ARB_RR_EN defined to check the round-robin tie policy.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MEM_LAT = 2;

`ifdef MEM_ARB_RR_EN
    localparam bit SECOND_TIE_D_FIRST = 1'b0;
`else
    localparam bit SECOND_TIE_D_FIRST = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              if_gnt;
    logic              d_gnt;
    logic              if_done;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    arb_state_t        dbgState;

    int nChecks = 0;
    int nFails  = 0;
    int ifGntCnt = 0;
    int dGntCnt = 0;
    int memWrCnt = 0;
    int ifDoneCnt = 0;
    int dDoneCnt = 0;

    // Expected completions: {owner is data, is store, read data}.
    logic [DATA_W+1:0] exp_q[$];

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .if_gnt    (if_gnt),
        .d_gnt     (d_gnt),
        .if_done   (if_done),
        .d_done    (d_done),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .dbgState  (dbgState)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Memory model: fixed contents per address plus one write slot.
    logic [ADDR_W-1:0] wrSlotAddr = '0;
    logic [DATA_W-1:0] wrSlotData = '0;
    logic              wrSlotValid = 1'b0;

    function automatic logic [DATA_W-1:0] memInit(input logic [ADDR_W-1:0] a);
        if (a == 64'h40) return 64'h0000_0000_00A0_0093;
        return {a[31:0], ~a[31:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            wrSlotAddr  <= mem_addr;
            wrSlotData  <= mem_wdata;
            wrSlotValid <= 1'b1;
        end
    end

    always_comb begin
        mem_rdata = memInit(mem_addr);
        if (wrSlotValid && (mem_addr == wrSlotAddr)) begin
            mem_rdata = wrSlotData;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: exclusive grants, done pulses matched to exp_q.
    always @(negedge clk) begin
        logic [DATA_W+1:0] e;
        check("one_gnt", 64'(if_gnt & d_gnt), 64'd0);
        if (if_gnt) ifGntCnt++;
        if (d_gnt) dGntCnt++;
        if (mem_wr) memWrCnt++;
        if (if_done) ifDoneCnt++;
        if (d_done) dDoneCnt++;
        if (if_done || d_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_owner", 64'(d_done), 64'(e[DATA_W+1]));
                check("done_single", 64'(if_done & d_done), 64'd0);
                if (!e[DATA_W]) begin
                    check("done_rdata", rdata, e[DATA_W-1:0]);
                end
            end
        end
    end

    // Both requests raised together, each held until its own done.
    task automatic doTie(input string tag, input bit dFirst);
        logic [63:0] firstAddr;
        logic [63:0] secondAddr;
        firstAddr  = dFirst ? 64'h80 : 64'h40;
        secondAddr = dFirst ? 64'h40 : 64'h80;
        if_req  = 1'b1;
        if_addr = 64'h40;
        d_req   = 1'b1;
        d_wr    = 1'b0;
        d_addr  = 64'h80;
        exp_q.push_back({dFirst, 1'b0, dFirst ? 64'h0000_0080_FFFF_FF7F : 64'h0000_0000_00A0_0093});
        exp_q.push_back({!dFirst, 1'b0, dFirst ? 64'h0000_0000_00A0_0093 : 64'h0000_0080_FFFF_FF7F});
        nextCycle();
        check({tag, "_first_d_gnt"}, 64'(d_gnt), 64'(dFirst));
        check({tag, "_first_if_gnt"}, 64'(if_gnt), 64'(!dFirst));
        check({tag, "_first_addr"}, mem_addr, firstAddr);
        nextCycle();
        nextCycle();
        check({tag, "_first_done"}, 64'(dFirst ? d_done : if_done), 64'd1);
        if (dFirst) d_req = 1'b0;
        else if_req = 1'b0;
        nextCycle();
        check({tag, "_gap_busy"}, 64'(busy), 64'd0);
        nextCycle();
        check({tag, "_second_d_gnt"}, 64'(d_gnt), 64'(!dFirst));
        check({tag, "_second_addr"}, mem_addr, secondAddr);
        nextCycle();
        nextCycle();
        check({tag, "_second_done"}, 64'(dFirst ? if_done : d_done), 64'd1);
        if_req = 1'b0;
        d_req  = 1'b0;
        nextCycle();
    endtask

    // Stimulus.
    initial begin
        int base;
        int baseWr;
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        check("rst_state", 64'(dbgState), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gnt", 64'({if_gnt, d_gnt}), 64'd0);
        check("rst_done", 64'({if_done, d_done}), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        reset = 1'b0;
        nextCycle();
        check("idle_no_req", 64'(busy), 64'd0);

        // Lone fetch.
        base = dGntCnt;
        if_req  = 1'b1;
        if_addr = 64'h40;
        exp_q.push_back({1'b0, 1'b0, 64'h0000_0000_00A0_0093});
        nextCycle();
        check("fetch_a1_addr", mem_addr, 64'h40);
        check("fetch_a1_wr", 64'(mem_wr), 64'd0);
        check("fetch_a1_gnt", 64'(if_gnt), 64'd1);
        check("fetch_a1_state", 64'(dbgState), 64'(ACCESS));
        nextCycle();
        check("fetch_a2_addr", mem_addr, 64'h40);
        check("fetch_a2_done", 64'(if_done), 64'd0);
        nextCycle();
        check("fetch_done", 64'(if_done), 64'd1);
        check("fetch_rdata", rdata, 64'h0000_0000_00A0_0093);
        if_req = 1'b0;
        nextCycle();
        check("fetch_after_done", 64'(if_done), 64'd0);
        check("fetch_after_busy", 64'(busy), 64'd0);
        check("fetch_no_d_gnt", 64'(dGntCnt - base), 64'd0);

        // Store with d_addr changed mid-ACCESS.
        base   = dDoneCnt;
        baseWr = memWrCnt;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 64'h100;
        d_wdata = 64'hDEAD_BEEF;
        exp_q.push_back({1'b1, 1'b1, 64'd0});
        nextCycle();
        check("store_a1_wr", 64'(mem_wr), 64'd1);
        check("store_a1_addr", mem_addr, 64'h100);
        check("store_a1_wdata", mem_wdata, 64'hDEAD_BEEF);
        check("store_a1_gnt", 64'({if_gnt, d_gnt}), 64'b01);
        d_addr = 64'h200;
        nextCycle();
        check("store_a2_wr", 64'(mem_wr), 64'd0);
        check("store_mid_change_addr", mem_addr, 64'h100);
        nextCycle();
        check("store_done", 64'(d_done), 64'd1);
        d_req = 1'b0;
        nextCycle();
        check("store_wr_count", 64'(memWrCnt - baseWr), 64'd1);
        check("store_done_count", 64'(dDoneCnt - base), 64'd1);

        // Load back the stored word.
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 64'h100;
        exp_q.push_back({1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF});
        nextCycle();
        check("load_a1_wr", 64'(mem_wr), 64'd0);
        nextCycle();
        nextCycle();
        check("load_done", 64'(d_done), 64'd1);
        check("load_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
        d_req = 1'b0;
        nextCycle();

        // Ties: the first always goes to data; the second depends on policy.
        doTie("tie1", 1'b1);
        doTie("tie2", SECOND_TIE_D_FIRST);

        // Reset in the first ACCESS cycle of a store.
        base    = dDoneCnt;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 64'h180;
        d_wdata = 64'h55AA;
        exp_q.push_back({1'b1, 1'b1, 64'd0});
        nextCycle();
        check("rstmid_a1_wr", 64'(mem_wr), 64'd1);
        reset = 1'b1;
        nextCycle();
        check("rstmid_wr", 64'(mem_wr), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_gnt", 64'({if_gnt, d_gnt}), 64'd0);
        check("rstmid_done", 64'(d_done), 64'd0);
        reset = 1'b0;
        nextCycle();
        check("rstmid_rearb_wr", 64'(mem_wr), 64'd1);
        check("rstmid_rearb_gnt", 64'(d_gnt), 64'd1);
        check("rstmid_rearb_addr", mem_addr, 64'h180);
        nextCycle();
        nextCycle();
        check("rstmid_done_pulse", 64'(d_done), 64'd1);
        d_req = 1'b0;
        nextCycle();
        check("rstmid_done_count", 64'(dDoneCnt - base), 64'd1);

        repeat (2) nextCycle();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
